activity_scheduler_16: RTL
==========================

// Module: activity_scheduler_16
// PURPOSE
//  Per-timestep activity scheduler for uCaspian's 16-slot activity bitmap.
//  Accumulates "slot active" marks during a timestep. On start it snapshots them into a working set.
//  Issues slot indices, highest index first, over a valid/ready handshake, then pulses done.
//  Sits between the event/synapse front end (mark producers) and the neuron-update pipeline (index consumer).
// PARAMETERS
//  CNT_W  5  width of issue_count; must be >= 5 so that a full run of 16 issues does not wrap
// PORTS
//  clk          in   1  single clock; all logic is on its rising edge
//  reset        in   1  synchronous, active-high reset
//  mark_valid   in   1  set pending bit mark_idx this cycle
//  mark_idx     in   4  slot to mark
//  start        in   1  begin a run; honoured only in IDLE
//  abort        in   1  terminate the current run, with no done pulse
//  out_valid    out  1  out_idx holds a slot to process
//  out_idx      out  4  highest set slot in the working set
//  out_ready    in   1  consumer accepts out_idx
//  busy         out  1  state != IDLE
//  done         out  1  one-cycle pulse: run complete
//  issue_count  out  CNT_W  slots issued in the current/last run
// BEHAVIOUR
//  Reset (sync, active-high; overrides all other inputs):
//   state=IDLE, pending=0, work=0, issue_count=0. Outputs out_valid/busy/done are 0.
//  Registers: pending[15:0] (next-timestep marks), work[15:0] (current run), state, issue_count.
//  States: IDLE, DRAIN, DONE (Moore outputs; out_valid/out_idx are combinational from work).
//  Marking: mark_valid sets pending[mark_idx] in every state. Duplicate marks are idempotent.
//  IDLE:
//   - start=1 and abort=0: work <= pending | (mark_valid ? onehot(mark_idx) : 0); pending <= 0.
//     This means a mark in the same cycle as start joins the run.
//   - Also on that start: issue_count <= 0; state -> DRAIN.
//  DRAIN:
//   - out_valid = (work != 0); out_idx = highest set bit of work.
//   - With work==0, out_idx = 0 and out_valid = 0.
//   - Handshake (out_valid & out_ready): clear work[out_idx]; issue_count++.
//   - If the handshake clears the last bit, state -> DONE next cycle.
//   - If work==0 on entry (empty run), state -> DONE next cycle.
//   - Marks in DRAIN go to pending only, never to work. Therefore out_valid/out_idx stay stable
//     until handshake or abort.
//  DONE: done=1 for exactly this one cycle; out_valid=0; state -> IDLE.
//  Latency:
//   - start at cycle t -> first out_valid at t+1.
//   - Back-to-back ready: one index per cycle.
//   - Last handshake at cycle k -> done at k+1, IDLE at k+2.
//   - Empty run: start t, DRAIN t+1, done t+2.
//  start outside IDLE is ignored (not queued).
//  abort in DRAIN/DONE: work <= 0; state -> IDLE next cycle; done not pulsed; pending and issue_count kept.
//  abort in IDLE: no effect. If start is also high, abort wins and the start is dropped.
//  Handshake and abort in the same cycle: the abort wins and the issue is not counted.
//  issue_count saturates at 2^CNT_W-1 and holds its value after a run until the next start.
// STRUCTURE
//  Package ucaspian_sched_pkg holds:
//   - typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} sched_state_t
//   - localparam NUM_SLOTS=16, SLOT_IDX_W=4
//  Sub-module: one existing find_set_bit_16 instance on work.
//   - out -> out_idx
//   - none_found -> ~out_valid (qualified by state==DRAIN)
//  Remaining logic: the FSM, two bitmaps and the counter, in this file.
// TESTING
//  1. Marks 3, 9, 15 in IDLE; start; out_ready=1.
//     -> out_idx 15, 9, 3 on consecutive cycles starting at t+1; done at t+4; issue_count=3.
//  2. Start with pending=0.
//     -> out_valid never asserts; done at t+2; busy high at t+1..t+2; issue_count=0.
//  3. Run with work={5,2} and out_ready low for 4 cycles; mark 7 during DRAIN.
//     -> out_idx holds 5 stably; 7 is not issued this run.
//     -> The next start issues only 7.
//  4. Mark 12 in the same cycle as start (pending={1}).
//     -> issues 12 then 1; pending=0 afterwards.
//  5. Abort mid-run after 1 of 3 issues.
//     -> IDLE next cycle; no done; issue_count=1; later marks and start still work.
//  6. Assert reset in DRAIN with a mark present.
//     -> next cycle: all outputs 0, pending=0, work=0; start is then accepted normally.

Source files
------------

// File: rtl/ucaspian_sched_pkg.sv
// Shared types and sizes for the uCaspian activity scheduler.
package ucaspian_sched_pkg;
   localparam int NUM_SLOTS  = 16;
   localparam int SLOT_IDX_W = 4;

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} sched_state_t;
endpackage

// File: rtl/find_set_bit_16.sv
// Priority encoder: index of the highest set bit of a 16-bit vector, 0 with none_found when empty.
// Purely combinational; no handshake.
module find_set_bit_16 (
   input  logic [15:0] vec,
   output logic [3:0]  out,
   output logic        none_found
);
   always_comb begin
      out        = 4'd0;
      none_found = (vec == 16'd0);
      // Ascending scan, so the highest set bit is the last one written.
      for (int i = 0; i < 16; i++) begin
         if (vec[i]) out = 4'(i);
      end
   end
endmodule

// File: rtl/activity_scheduler_16.sv
// Snapshots per-timestep slot marks at start and issues them highest-first; one index per cycle.
// Latency: start -> first index next cycle; backpressure: index held stable while out_ready is low.
module activity_scheduler_16
   import ucaspian_sched_pkg::*;
#(
   parameter int CNT_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mark_valid,
   input  logic [SLOT_IDX_W-1:0] mark_idx,
   input  logic                  start,
   input  logic                  abort,
   output logic                  out_valid,
   output logic [SLOT_IDX_W-1:0] out_idx,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_W-1:0]      issue_count
);
   sched_state_t         state;
   logic [NUM_SLOTS-1:0] pending;
   logic [NUM_SLOTS-1:0] work;
   logic [NUM_SLOTS-1:0] mark_vec;
   logic [NUM_SLOTS-1:0] issue_vec;
   logic [NUM_SLOTS-1:0] work_after_issue;
   logic [SLOT_IDX_W-1:0] top_idx;
   logic                  none_found;
   logic                  handshake;

   find_set_bit_16 u_find (
      .vec        (work),
      .out        (top_idx),
      .none_found (none_found)
   );

   assign mark_vec         = mark_valid ? (NUM_SLOTS'(1) << mark_idx) : '0;
   assign issue_vec        = NUM_SLOTS'(1) << top_idx;
   assign work_after_issue = work & ~issue_vec;

   assign out_valid = (state == S_DRAIN) && !none_found;
   assign out_idx   = top_idx;
   assign handshake = out_valid && out_ready;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         pending     <= '0;
         work        <= '0;
         issue_count <= '0;
      end else begin
         pending <= pending | mark_vec;
         case (state)
            S_IDLE: begin
               // A mark coinciding with start joins this run rather than the next.
               if (start && !abort) begin
                  work        <= pending | mark_vec;
                  pending     <= '0;
                  issue_count <= '0;
                  state       <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (abort) begin
                  work  <= '0;
                  state <= S_IDLE;
               end else if (handshake) begin
                  work <= work_after_issue;
                  if (issue_count != '1) issue_count <= issue_count + CNT_W'(1);
                  if (work_after_issue == '0) state <= S_DONE;
               end else if (work == '0) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               work  <= '0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
